// File: rtl/vga_pattern_gen_if.sv
// Pixel-side bundle of the VGA pattern generator: switch/mode inputs and connector outputs.
// The master modport is the generator; the slave modport is the board or consumer side.
interface vga_pattern_gen_if #(
    parameter int unsigned COLOR_BITS = 1,
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 10
);
    logic                  red_in;
    logic                  green_in;
    logic                  blue_in;
    logic [1:0]            mode_sel;
    logic [COLOR_BITS-1:0] red_out;
    logic [COLOR_BITS-1:0] green_out;
    logic [COLOR_BITS-1:0] blue_out;
    logic                  hsync;
    logic                  vsync;
    logic                  video_on;
    logic [XW-1:0]         pixel_x;
    logic [YW-1:0]         pixel_y;
    logic                  frame_start;

    modport master (
        input  red_in, green_in, blue_in, mode_sel,
        output red_out, green_out, blue_out, hsync, vsync,
               video_on, pixel_x, pixel_y, frame_start
    );

    modport slave (
        output red_in, green_in, blue_in, mode_sel,
        input  red_out, green_out, blue_out, hsync, vsync,
               video_on, pixel_x, pixel_y, frame_start
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and colour pattern generator with frame-synchronous switch capture.
// All outputs are registered and describe the (h,v) counter state of the previous clock.
module vga_pattern_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned COLOR_BITS = 1,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    vga_pattern_gen_if.master  bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_TOTAL);
    localparam int unsigned AW      = $clog2(H_ACTIVE);
    localparam int unsigned CW      = COLOR_BITS;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_X = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_LEN  = XW'(H_SYNC);
    localparam logic [XW-1:0] BAR_W_X = XW'(BAR_W);
    localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_Y = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_LEN  = YW'(V_SYNC);
    localparam logic [CW-1:0] FULL    = '1;

    logic [XW-1:0] h;
    logic [YW-1:0] v;
    logic [4:0]    sync_q1;
    logic [4:0]    sync_q2;
    logic [2:0]    sw;
    logic [1:0]    mode;

    logic          frame_end_c;
    logic          active_c;
    logic          hsync_c;
    logic          vsync_c;
    logic          checker_c;
    logic [2:0]    bar_c;
    logic [2:0]    mask_c;
    logic [CW-1:0] grad_c;
    logic [CW-1:0] red_c;
    logic [CW-1:0] green_c;
    logic [CW-1:0] blue_c;

    // Raster counters
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + YW'(1);
        end else begin
            h <= h + XW'(1);
        end
    end

    // Two-flop synchroniser, then a frame-boundary load so a frame never tears
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            sw      <= '0;
            mode    <= '0;
        end else begin
            sync_q1 <= {bus.red_in, bus.green_in, bus.blue_in, bus.mode_sel};
            sync_q2 <= sync_q1;
            if (frame_end_c) begin
                sw   <= sync_q2[4:2];
                mode <= sync_q2[1:0];
            end
        end
    end

    // Timing decode of the current counter state
    always_comb begin
        frame_end_c = (h == H_LAST) && (v == V_LAST);
        active_c    = (h < H_ACT_X) && (v < V_ACT_Y);
        hsync_c     = ~SYNC_POL;
        vsync_c     = ~SYNC_POL;
        if ((h >= HS_BEG) && ((h - HS_BEG) < HS_LEN)) begin
            hsync_c = SYNC_POL;
        end
        if ((v >= VS_BEG) && ((v - VS_BEG) < VS_LEN)) begin
            vsync_c = SYNC_POL;
        end
    end

    // Pattern colour; modes 0-2 give an on/off mask, mode 3 a horizontal ramp
    always_comb begin
        bar_c     = 3'd7 - 3'(h / BAR_W_X);
        checker_c = h[CHECK_LOG2] ^ v[CHECK_LOG2];
        grad_c    = h[AW-1 -: CW];
        mask_c    = sw;
        case (mode)
            2'd1:    mask_c = bar_c;
            2'd2:    mask_c = checker_c ? ~sw : sw;
            default: mask_c = sw;
        endcase
        red_c   = mask_c[2] ? FULL : '0;
        green_c = mask_c[1] ? FULL : '0;
        blue_c  = mask_c[0] ? FULL : '0;
        if (mode == 2'd3) begin
            red_c   = sw[2] ? grad_c : '0;
            green_c = sw[1] ? grad_c : '0;
            blue_c  = sw[0] ? grad_c : '0;
        end
        if (!active_c) begin
            red_c   = '0;
            green_c = '0;
            blue_c  = '0;
        end
    end

    // Output register stage: one clock behind the counters, all outputs aligned
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.red_out     <= '0;
            bus.green_out   <= '0;
            bus.blue_out    <= '0;
            bus.hsync       <= ~SYNC_POL;
            bus.vsync       <= ~SYNC_POL;
            bus.video_on    <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.pixel_x     <= '0;
            bus.pixel_y     <= '0;
        end else begin
            bus.red_out     <= red_c;
            bus.green_out   <= green_c;
            bus.blue_out    <= blue_c;
            bus.hsync       <= hsync_c;
            bus.vsync       <= vsync_c;
            bus.video_on    <= active_c;
            bus.frame_start <= (h == '0) && (v == '0);
            bus.pixel_x     <= h;
            bus.pixel_y     <= v;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a reduced 80x56 raster (64x48 visible).
// Two instances: 1-bit colour with active-low sync, 4-bit colour with active-high sync.
module tb_vga_pattern_gen;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 48, VF = 2, VS = 2, VB = 4, VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int unsigned XW = $clog2(HT);
    localparam int unsigned YW = $clog2(VT);

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic       r_sw, g_sw, b_sw;
    logic [1:0] mode;
    int         total = 0;
    int         bad = 0;

    always #5 vga_clk = ~vga_clk;

    vga_pattern_gen_if #(.COLOR_BITS(1), .XW(XW), .YW(YW)) bus1 ();
    vga_pattern_gen_if #(.COLOR_BITS(4), .XW(XW), .YW(YW)) bus4 ();

    assign bus1.red_in   = r_sw;
    assign bus1.green_in = g_sw;
    assign bus1.blue_in  = b_sw;
    assign bus1.mode_sel = mode;
    assign bus4.red_in   = r_sw;
    assign bus4.green_in = g_sw;
    assign bus4.blue_in  = b_sw;
    assign bus4.mode_sel = mode;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .COLOR_BITS(1), .SYNC_POL(1'b0), .CHECK_LOG2(5)
    ) dut1 (.vga_clk(vga_clk), .reset_n(reset_n), .bus(bus1));

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .COLOR_BITS(4), .SYNC_POL(1'b1), .CHECK_LOG2(5)
    ) dut4 (.vga_clk(vga_clk), .reset_n(reset_n), .bus(bus4));

    task automatic skip(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    // Advance to the next negedge on which frame_start is high, bounded by two frames
    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge vga_clk);
            n++;
        end while (bus1.frame_start !== 1'b1 && n < 2 * FRAME + 10);
        total++;
        if (bus1.frame_start !== 1'b1) begin
            bad++;
            $display("FAIL wait_frame: frame_start=%b after %0d cycles, required 1", bus1.frame_start, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        r_sw = 1'b0; g_sw = 1'b0; b_sw = 1'b0; mode = 2'd0;
        skip(5);
        total++;
        if ({bus1.hsync, bus1.vsync, bus4.hsync, bus4.vsync} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_sync: got %b, required 1100", {bus1.hsync, bus1.vsync, bus4.hsync, bus4.vsync});
        end
        total++;
        if ({bus1.red_out, bus1.green_out, bus1.blue_out, bus4.red_out, bus4.green_out, bus4.blue_out} !== 15'h0) begin
            bad++;
            $display("FAIL reset_colour: got %h, required 0",
                     {bus1.red_out, bus1.green_out, bus1.blue_out, bus4.red_out, bus4.green_out, bus4.blue_out});
        end
        total++;
        if ({bus1.video_on, bus1.frame_start, bus1.pixel_x, bus1.pixel_y} !== {2'b00, XW'(0), YW'(0)}) begin
            bad++;
            $display("FAIL reset_misc: video_on=%b frame_start=%b x=%0d y=%0d, required all 0",
                     bus1.video_on, bus1.frame_start, bus1.pixel_x, bus1.pixel_y);
        end
        reset_n = 1'b1;
        @(negedge vga_clk);
        total++;
        if ({bus1.frame_start, bus4.frame_start, bus1.video_on} !== 3'b111 ||
            bus1.pixel_x !== XW'(0) || bus1.pixel_y !== YW'(0)) begin
            bad++;
            $display("FAIL first_frame_start: fs1=%b fs4=%b video=%b x=%0d y=%0d, required 1 1 1 0 0",
                     bus1.frame_start, bus4.frame_start, bus1.video_on, bus1.pixel_x, bus1.pixel_y);
        end
    endtask

    task automatic test_timing();
        int err, first_k, hs_low, vs_low, vid, fs_cnt, x, y;
        logic e_hs, e_vs, e_vid, e_fs;
        err = 0; first_k = -1; hs_low = 0; vs_low = 0; vid = 0; fs_cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            x = k % HT;
            y = (k / HT) % VT;
            e_hs  = !(x >= HA + HF && x < HA + HF + HS);
            e_vs  = !(y >= VA + VF && y < VA + VF + VS);
            e_vid = (x < HA) && (y < VA);
            e_fs  = (x == 0) && (y == 0);
            if ({bus1.hsync, bus1.vsync, bus1.video_on, bus1.frame_start} !== {e_hs, e_vs, e_vid, e_fs} ||
                bus1.pixel_x !== XW'(x) || bus1.pixel_y !== YW'(y) ||
                {bus4.hsync, bus4.vsync, bus4.frame_start, bus4.video_on} !== {~e_hs, ~e_vs, e_fs, e_vid} ||
                {bus1.red_out, bus1.green_out, bus1.blue_out} !== 3'b000 ||
                {bus4.red_out, bus4.green_out, bus4.blue_out} !== 12'h000) begin
                if (err == 0) first_k = k;
                err++;
            end
            if (bus1.hsync === 1'b0) hs_low++;
            if (bus1.vsync === 1'b0) vs_low++;
            if (bus1.video_on === 1'b1) vid++;
            if (bus1.frame_start === 1'b1) fs_cnt++;
            @(negedge vga_clk);
        end
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL timing_model: %0d mismatching cycles, first at cycle %0d, required 0", err, first_k);
        end
        total++;
        if (hs_low !== 2 * HS * VT) begin
            bad++;
            $display("FAIL hsync_low_count: got %0d, required %0d", hs_low, 2 * HS * VT);
        end
        total++;
        if (vs_low !== 2 * VS * HT) begin
            bad++;
            $display("FAIL vsync_low_count: got %0d, required %0d", vs_low, 2 * VS * HT);
        end
        total++;
        if (vid !== 2 * HA * VA) begin
            bad++;
            $display("FAIL video_on_count: got %0d, required %0d", vid, 2 * HA * VA);
        end
        total++;
        if (fs_cnt !== 2) begin
            bad++;
            $display("FAIL frame_start_count: got %0d, required 2", fs_cnt);
        end
    endtask

    task automatic test_mode0();
        int err, first_k, x, y;
        logic e_act;
        r_sw = 1'b1; g_sw = 1'b0; b_sw = 1'b1; mode = 2'd0;
        skip(5 * HT + 10);
        total++;
        if ({bus1.red_out, bus1.green_out, bus1.blue_out, bus4.red_out} !== 7'h00 || bus1.video_on !== 1'b1) begin
            bad++;
            $display("FAIL mode0_midframe: rgb1=%b red4=%h video=%b, required 000 0 1",
                     {bus1.red_out, bus1.green_out, bus1.blue_out}, bus4.red_out, bus1.video_on);
        end
        wait_frame();
        err = 0; first_k = -1;
        for (int k = 0; k < FRAME; k++) begin
            x = k % HT;
            y = k / HT;
            e_act = (x < HA) && (y < VA);
            if ({bus1.red_out, bus1.green_out, bus1.blue_out} !== (e_act ? 3'b101 : 3'b000) ||
                {bus4.red_out, bus4.green_out, bus4.blue_out} !== (e_act ? 12'hF0F : 12'h000)) begin
                if (err == 0) first_k = k;
                err++;
            end
            if (k == 20 * HT) g_sw = 1'b1;
            @(negedge vga_clk);
        end
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL mode0_frame: %0d mismatching cycles, first at cycle %0d, required 0", err, first_k);
        end
        total++;
        if (bus1.frame_start !== 1'b1 || {bus1.red_out, bus1.green_out, bus1.blue_out} !== 3'b111 ||
            {bus4.red_out, bus4.green_out, bus4.blue_out} !== 12'hFFF) begin
            bad++;
            $display("FAIL mode0_green_update: fs=%b rgb1=%b rgb4=%h, required 1 111 fff", bus1.frame_start,
                     {bus1.red_out, bus1.green_out, bus1.blue_out}, {bus4.red_out, bus4.green_out, bus4.blue_out});
        end
    endtask

    task automatic test_mode1();
        int         xs[12] = '{0, 7, 8, 15, 16, 31, 32, 55, 56, 63, 64, 79};
        logic [2:0] er[12] = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b101, 3'b100,
                               3'b011, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [11:0] e4;
        int cur;
        mode = 2'd1;
        wait_frame();
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            skip(xs[i] - cur);
            cur = xs[i];
            e4 = {{4{er[i][2]}}, {4{er[i][1]}}, {4{er[i][0]}}};
            total++;
            if ({bus1.red_out, bus1.green_out, bus1.blue_out} !== er[i] ||
                {bus4.red_out, bus4.green_out, bus4.blue_out} !== e4) begin
                bad++;
                $display("FAIL mode1_bar x=%0d: rgb1=%b rgb4=%h, required %b %h", xs[i],
                         {bus1.red_out, bus1.green_out, bus1.blue_out},
                         {bus4.red_out, bus4.green_out, bus4.blue_out}, er[i], e4);
            end
        end
    endtask

    task automatic test_mode2();
        int         ks[7] = '{0, 32, 10 * HT + 40, 31 * HT + 31, 32 * HT, 32 * HT + 32, 47 * HT + 63};
        logic [2:0] er[7] = '{3'b100, 3'b011, 3'b011, 3'b100, 3'b011, 3'b100, 3'b100};
        logic [11:0] e4;
        int cur;
        r_sw = 1'b1; g_sw = 1'b0; b_sw = 1'b0; mode = 2'd2;
        wait_frame();
        cur = 0;
        for (int i = 0; i < 7; i++) begin
            skip(ks[i] - cur);
            cur = ks[i];
            e4 = {{4{er[i][2]}}, {4{er[i][1]}}, {4{er[i][0]}}};
            total++;
            if ({bus1.red_out, bus1.green_out, bus1.blue_out} !== er[i] ||
                {bus4.red_out, bus4.green_out, bus4.blue_out} !== e4) begin
                bad++;
                $display("FAIL mode2_checker (%0d,%0d): rgb1=%b rgb4=%h, required %b %h", ks[i] % HT, ks[i] / HT,
                         {bus1.red_out, bus1.green_out, bus1.blue_out},
                         {bus4.red_out, bus4.green_out, bus4.blue_out}, er[i], e4);
            end
        end
    endtask

    task automatic test_mode3();
        int         xs[6] = '{0, 4, 20, 32, 63, 64};
        logic [3:0] g4[6] = '{4'h0, 4'h1, 4'h5, 4'h8, 4'hF, 4'h0};
        logic       g1[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int cur;
        r_sw = 1'b1; g_sw = 1'b1; b_sw = 1'b1; mode = 2'd3;
        wait_frame();
        cur = 0;
        for (int i = 0; i < 6; i++) begin
            skip(xs[i] - cur);
            cur = xs[i];
            total++;
            if ({bus4.red_out, bus4.green_out, bus4.blue_out} !== {3{g4[i]}} ||
                {bus1.red_out, bus1.green_out, bus1.blue_out} !== {3{g1[i]}}) begin
                bad++;
                $display("FAIL mode3_gradient x=%0d: rgb4=%h rgb1=%b, required %h %b", xs[i],
                         {bus4.red_out, bus4.green_out, bus4.blue_out},
                         {bus1.red_out, bus1.green_out, bus1.blue_out}, {3{g4[i]}}, {3{g1[i]}});
            end
        end
    endtask

    task automatic test_reset_mid();
        skip(10 * HT + 20 - 64);
        total++;
        if (bus4.red_out !== 4'h5 || bus1.pixel_y !== YW'(10)) begin
            bad++;
            $display("FAIL pre_reset_pixel: red4=%h y=%0d, required 5 10", bus4.red_out, bus1.pixel_y);
        end
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({bus1.hsync, bus1.vsync, bus4.hsync, bus4.vsync, bus1.video_on, bus1.frame_start} !== 6'b110000 ||
            {bus4.red_out, bus4.green_out, bus4.blue_out, bus1.red_out} !== 13'h0 ||
            bus1.pixel_x !== XW'(0) || bus1.pixel_y !== YW'(0)) begin
            bad++;
            $display("FAIL async_reset: sync=%b video=%b fs=%b rgb4=%h x=%0d y=%0d, required 1100 0 0 000 0 0",
                     {bus1.hsync, bus1.vsync, bus4.hsync, bus4.vsync}, bus1.video_on, bus1.frame_start,
                     {bus4.red_out, bus4.green_out, bus4.blue_out}, bus1.pixel_x, bus1.pixel_y);
        end
        skip(3);
        reset_n = 1'b1;
        @(negedge vga_clk);
        total++;
        if (bus1.frame_start !== 1'b1 || bus1.pixel_x !== XW'(0) || bus1.pixel_y !== YW'(0)) begin
            bad++;
            $display("FAIL restart_origin: fs=%b x=%0d y=%0d, required 1 0 0",
                     bus1.frame_start, bus1.pixel_x, bus1.pixel_y);
        end
        skip(32);
        total++;
        if ({bus4.red_out, bus4.green_out, bus4.blue_out} !== 12'h000 || bus4.video_on !== 1'b1) begin
            bad++;
            $display("FAIL restart_black: rgb4=%h video=%b, required 000 1",
                     {bus4.red_out, bus4.green_out, bus4.blue_out}, bus4.video_on);
        end
        wait_frame();
        skip(32);
        total++;
        if ({bus4.red_out, bus4.green_out, bus4.blue_out} !== 12'h888) begin
            bad++;
            $display("FAIL restart_reload: rgb4=%h, required 888", {bus4.red_out, bus4.green_out, bus4.blue_out});
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_mode0();
        test_mode1();
        test_mode2();
        test_mode3();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
